// File: rtl/checksum_strip.sv
// rtl/checksum_strip.sv - strips and verifies per-group checksum beats from a data stream
//
// Purpose:
//   A checksum beat follows every GROUP data beats, or any data beat carrying
//   inp_last. Data beats are summed (32-bit words, bytes masked by keep) and
//   forwarded through a one-beat registered output stage. Checksum beats are
//   compared against the running sum plus the stored last/id. They are never
//   forwarded. A failed group pulses chk_err with chk_valid and bumps a
//   saturating error counter.
//
// Ports:
//   clock                      rising-edge clock
//   reset                      synchronous active-low reset
//   inp_data/keep/id/last      input beat payload and sideband
//   inp_valid/inp_ready        input handshake
//   out/out_keep/out_id/out_last  forwarded data beat and sideband
//   out_valid/out_ready        output handshake
//   chk_valid/chk_err          one-cycle verdict pulse and failure flag
//   err_count                  saturating count of failed groups
module checksum_strip #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 6,
  parameter int GROUP  = 4,
  parameter int ERR_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] inp_data,
  input  logic              inp_valid,
  output logic              inp_ready,
  input  logic [KEEP_W-1:0] inp_keep,
  input  logic [ID_W-1:0]   inp_id,
  input  logic              inp_last,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last,
  output logic              chk_valid,
  output logic              chk_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int NWORDS = DATA_W / 32;
  localparam int CNT_W  = $clog2(GROUP + 1);

  localparam logic [0:0] ST_DATA = 1'b0;
  localparam logic [0:0] ST_CHK  = 1'b1;

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_acc;
  logic              r_last;
  logic [ID_W-1:0]   r_id;
  logic              r_run;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic [KEEP_W-1:0] r_out_keep;
  logic [ID_W-1:0]   r_out_id;
  logic              r_out_last;
  logic              r_chk_valid;
  logic              r_chk_err;
  logic [ERR_W-1:0]  r_err_count;

  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_masked;
  logic [31:0]       w_beat_sum;
  logic              w_in_fire;
  logic              w_data_fire;
  logic              w_chk_fire;
  logic              w_chk_fail;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_grp_end;
  logic              w_err_max;

  // Expand byte enables into a bit mask so disabled bytes contribute zero.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      w_mask[i*8 +: 8] = {8{inp_keep[i]}};
    end
  end

  assign w_masked = inp_data & w_mask;

  always_comb begin
    w_beat_sum = '0;
    for (int w = 0; w < NWORDS; w++) begin
      w_beat_sum = w_beat_sum + w_masked[w*32 +: 32];
    end
  end

  // r_run holds ready low through reset and releases it one edge after.
  // In CHK the checksum beat is consumed internally, so output stalls do not block it.
  assign inp_ready   = reset && r_run &&
                       ((r_state == ST_CHK) || !r_out_valid || out_ready);
  assign w_in_fire   = inp_valid && inp_ready;
  assign w_data_fire = w_in_fire && (r_state == ST_DATA);
  assign w_chk_fire  = w_in_fire && (r_state == ST_CHK);
  assign w_cnt_next  = r_cnt + 1'b1;
  assign w_grp_end   = inp_last || (w_cnt_next == CNT_W'(GROUP));
  assign w_chk_fail  = (inp_data[31:0] != r_acc) || (inp_last != r_last) ||
                       (inp_id != r_id);
  assign w_err_max   = &r_err_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_DATA;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_last      <= 1'b0;
      r_id        <= '0;
      r_run       <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_keep  <= '0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
      r_chk_valid <= 1'b0;
      r_chk_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_run       <= 1'b1;
      r_chk_valid <= w_chk_fire;
      r_chk_err   <= w_chk_fire && w_chk_fail;

      if (w_data_fire) begin
        r_acc       <= r_acc + w_beat_sum;
        r_last      <= inp_last;
        r_id        <= inp_id;
        r_out       <= inp_data;
        r_out_keep  <= inp_keep;
        r_out_id    <= inp_id;
        r_out_last  <= inp_last;
        r_out_valid <= 1'b1;
        if (w_grp_end) begin
          r_state <= ST_CHK;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_chk_fire) begin
        r_acc   <= '0;
        r_state <= ST_DATA;
        if (w_chk_fail && !w_err_max) begin
          r_err_count <= r_err_count + 1'b1;
        end
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_keep  = r_out_keep;
  assign out_id    = r_out_id;
  assign out_last  = r_out_last;
  assign chk_valid = r_chk_valid;
  assign chk_err   = r_chk_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_checksum_strip.sv
// tb/tb_checksum_strip.sv - self-checking bench for checksum_strip
module tb_checksum_strip;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int IW = 6;
  localparam int G  = 4;
  localparam int EW = 4;
  localparam int EMAX = (1 << EW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] inp_data = '0;
  logic          inp_valid = 1'b0;
  logic          inp_ready;
  logic [KW-1:0] inp_keep = '0;
  logic [IW-1:0] inp_id = '0;
  logic          inp_last = 1'b0;
  logic [DW-1:0] out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [KW-1:0] out_keep;
  logic [IW-1:0] out_id;
  logic          out_last;
  logic          chk_valid;
  logic          chk_err;
  logic [EW-1:0] err_count;

  checksum_strip #(.DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .GROUP(G), .ERR_W(EW)) dut (
    .clock(clock), .reset(reset),
    .inp_data(inp_data), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_keep(out_keep), .out_id(out_id), .out_last(out_last),
    .chk_valid(chk_valid), .chk_err(chk_err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  typedef struct {
    bit err;
    int cnt;
  } verdict_t;

  beat_t    exp_q[$];
  verdict_t ver_q[$];

  int checks = 0;
  int errors = 0;
  bit in_rst = 1'b1;
  bit bp_random = 1'b0;

  // Stream-level model of the current group.
  logic [31:0]   m_acc = '0;
  logic          m_last = 1'b0;
  logic [IW-1:0] m_id = '0;
  int            m_err = 0;

  function automatic void check(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Byte-wise checksum: each enabled byte weighted by its position within its 32-bit word.
  function automatic logic [31:0] beat_sum(input logic [DW-1:0] d, input logic [KW-1:0] k);
    logic [31:0] s;
    s = '0;
    for (int b = 0; b < KW; b++) begin
      if (k[b]) s = s + (32'(d[b*8 +: 8]) << (8 * (b % 4)));
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] word0(input logic [31:0] w);
    logic [DW-1:0] v;
    v = '0;
    v[31:0] = w;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [KW-1:0] rand_keep();
    logic [KW-1:0] v;
    for (int w = 0; w < KW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [IW-1:0] id, input logic last,
                           input bit is_chk, input int gap);
    int n;
    beat_t b;
    verdict_t v;
    inp_data = d; inp_keep = k; inp_id = id; inp_last = last; inp_valid = 1'b1;
    n = 0;
    @(negedge clock);
    if (is_chk) check("chk_beat_ready", inp_ready, 1);
    while (!inp_ready && n < 500) begin
      n++;
      @(negedge clock);
    end
    if (!inp_ready) begin
      check("accept_timeout", 0, 1);
      @(posedge clock); #1;
      inp_valid = 1'b0;
      return;
    end
    if (!is_chk) begin
      b.d = d; b.k = k; b.id = id; b.last = last;
      exp_q.push_back(b);
      m_acc  = m_acc + beat_sum(d, k);
      m_last = last;
      m_id   = id;
    end else begin
      v.err = (d[31:0] != m_acc) || (last != m_last) || (id != m_id);
      if (v.err && m_err < EMAX) m_err++;
      v.cnt = m_err;
      ver_q.push_back(v);
      m_acc = '0;
    end
    @(posedge clock); #1;
    inp_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ver_q.size() != 0) && n < 100) begin
      @(posedge clock);
      n++;
    end
    @(posedge clock); #1;
    check("drain", exp_q.size() + ver_q.size(), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_out"}, out, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_keep"}, out_keep, 0);
    check({tag, "_out_id"}, out_id, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_chk_valid"}, chk_valid, 0);
    check({tag, "_chk_err"}, chk_err, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_inp_ready"}, inp_ready, 0);
  endtask

  // Output-ready driver.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Compare process: forwarded beats, hold stability and verdicts.
  initial begin
    bit    prev_stall;
    beat_t held;
    beat_t e;
    verdict_t v;
    prev_stall = 1'b0;
    forever begin
      @(negedge clock);
      if (in_rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out, held.d);
        check("hold_keep", out_keep, held.k);
        check("hold_id", out_id, held.id);
        check("hold_last", out_last, held.last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out, e.d);
          check("out_keep", out_keep, e.k);
          check("out_id", out_id, e.id);
          check("out_last", out_last, e.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      held.d = out; held.k = out_keep; held.id = out_id; held.last = out_last;
      if (chk_valid) begin
        if (ver_q.size() == 0) begin
          check("verdict_unexpected", 1, 0);
        end else begin
          v = ver_q.pop_front();
          check("chk_err", chk_err, v.err);
          check("err_count", err_count, v.cnt);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [IW-1:0] id;
    logic [DW-1:0] cd;
    logic          cl;
    logic [IW-1:0] cid;
    int len, ngrp, mode;

    ones = '1;

    // Model pins.
    check("pin_sum_ones", beat_sum(ones, '1), 32'hFFFF_FFF0);
    check("pin_sum_keep1", beat_sum(word0(32'hAABB_CCDD), 64'h1), 32'h0000_00DD);
    check("pin_sum_5", beat_sum(word0(32'd5), '1), 32'd5);

    // Reset.
    reset = 1'b0; in_rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst0");
    reset = 1'b1; in_rst = 1'b0;
    @(posedge clock); #1;
    check("ready_after_rst0", inp_ready, 1);

    // Scenario 1: four all-ones beats.
    for (int i = 0; i < 4; i++) send_beat(ones, '1, 6'h2A, 1'b0, 1'b0, 0);
    check("pin_grp_sum", m_acc, 32'hFFFF_FFC0);
    send_beat(word0(32'hFFFF_FFC0), '1, 6'h2A, 1'b0, 1'b1, 0);
    drain();
    check("s1_err_count", err_count, 0);

    // Scenario 2: short packet, good checksum.
    send_beat(word0(32'd5), '1, 6'h05, 1'b0, 1'b0, 0);
    send_beat(word0(32'd7), '1, 6'h05, 1'b1, 1'b0, 0);
    send_beat(word0(32'd12), '1, 6'h05, 1'b1, 1'b1, 0);
    drain();
    check("s2_err_count", err_count, 0);

    // Scenario 3: same with bad checksum.
    send_beat(word0(32'd5), '1, 6'h05, 1'b0, 1'b0, 0);
    send_beat(word0(32'd7), '1, 6'h05, 1'b1, 1'b0, 0);
    send_beat(word0(32'd13), '1, 6'h05, 1'b1, 1'b1, 0);
    drain();
    check("s3_err_count", err_count, 1);

    // Scenario 4: partial keep, pass then last mismatch.
    send_beat(word0(32'hAABB_CCDD), 64'h1, 6'h11, 1'b1, 1'b0, 0);
    send_beat(word0(32'hDD), '1, 6'h11, 1'b1, 1'b1, 0);
    drain();
    check("s4a_err_count", err_count, 1);
    send_beat(word0(32'hAABB_CCDD), 64'h1, 6'h11, 1'b1, 1'b0, 0);
    send_beat(word0(32'hDD), '1, 6'h11, 1'b0, 1'b1, 0);
    drain();
    check("s4b_err_count", err_count, 2);

    // Backpressure: stall five cycles mid-group, then verdict while stalled.
    out_ready = 1'b0;
    send_beat(rand_data(), '1, 6'h21, 1'b0, 1'b0, 0);
    inp_data = rand_data(); inp_keep = '1; inp_id = 6'h21; inp_last = 1'b0; inp_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("bp_ready_data", inp_ready, 0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    send_beat(inp_data, '1, 6'h21, 1'b0, 1'b0, 0);
    send_beat(rand_data(), '1, 6'h21, 1'b1, 1'b0, 0);
    out_ready = 1'b0;
    cd = rand_data(); cd[31:0] = m_acc;
    send_beat(cd, rand_keep(), 6'h21, 1'b1, 1'b1, 0);
    repeat (3) @(posedge clock);
    #1;
    check("bp_verdict_done", ver_q.size(), 0);
    out_ready = 1'b1;
    drain();

    // Reset mid-group with a held output beat.
    send_beat(rand_data(), '1, 6'h33, 1'b0, 1'b0, 0);
    drain();
    out_ready = 1'b0;
    send_beat(rand_data(), '1, 6'h33, 1'b0, 1'b0, 0);
    reset = 1'b0; in_rst = 1'b1;
    @(posedge clock); #1;
    check_reset_outputs("rst1");
    repeat (2) @(posedge clock);
    #1;
    exp_q.delete(); ver_q.delete();
    m_acc = '0; m_err = 0;
    reset = 1'b1; in_rst = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    check("ready_after_rst1", inp_ready, 1);
    d = rand_data();
    send_beat(d, '1, 6'h07, 1'b1, 1'b0, 0);
    cd = '0; cd[31:0] = m_acc;
    send_beat(cd, '1, 6'h07, 1'b1, 1'b1, 0);
    drain();
    check("rst1_err_count", err_count, 0);

    // Randomized packets with random keep, gaps, backpressure and corruption.
    bp_random = 1'b1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 9);
      id = IW'($urandom);
      ngrp = 0;
      for (int i = 0; i < len; i++) begin
        d = rand_data();
        k = ($urandom_range(0, 2) == 0) ? rand_keep() : '1;
        send_beat(d, k, id, (i == len - 1), 1'b0, ($urandom_range(0, 4) == 0) ? 1 : 0);
        ngrp++;
        if (i == len - 1 || ngrp == G) begin
          cd = rand_data(); cd[31:0] = m_acc;
          cl = m_last; cid = m_id;
          mode = $urandom_range(0, 9);
          if (mode == 0) cd[$urandom_range(0, 31)] ^= 1'b1;
          if (mode == 1) cl = ~cl;
          if (mode == 2) cid[$urandom_range(0, IW - 1)] ^= 1'b1;
          send_beat(cd, rand_keep(), cid, cl, 1'b1, 0);
          ngrp = 0;
        end
      end
    end
    bp_random = 1'b0;
    out_ready = 1'b1;
    drain();
    check("final_err_count", err_count, m_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
